// File: rtl/teclado_cajero_if.sv
// Keypad-to-ATM-controller bundle: raw keypad level inputs plus the accepted
// digit/amount outputs. The keypad block is the master.
interface teclado_cajero_if;
  logic        tarjeta_recibida;
  logic        modo_monto;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        monto_stb;
  logic [31:0] monto;
  logic [3:0]  digitos_cnt;

  modport master (
    input  tarjeta_recibida,
    input  modo_monto,
    input  tecla_valida,
    input  tecla,
    output digito_stb,
    output digito,
    output monto_stb,
    output monto,
    output digitos_cnt
  );

  modport slave (
    output tarjeta_recibida,
    output modo_monto,
    output tecla_valida,
    output tecla,
    input  digito_stb,
    input  digito,
    input  monto_stb,
    input  monto,
    input  digitos_cnt
  );
endinterface

// File: rtl/teclado_cajero.sv
// ATM keypad front end: debounces key presses, forwards PIN digits one by one
// and accumulates decimal amounts delivered on Enter.
module teclado_cajero #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITOS     = 9
) (
  input  logic             clk,
  input  logic             reset,
  teclado_cajero_if.master bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntUltimo = CntW'((DEBOUNCE_CYCLES < 2) ? 0 : DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MaxDig = 4'(MAX_DIGITOS);
  localparam logic [3:0] TeclaEnter = 4'hA;
  localparam logic [3:0] TeclaClear = 4'hB;

  typedef enum logic [1:0] {StIdle, StFiltro, StAceptar, StSoltar} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      tecla_prev_q, tecla_prev_d;
  logic            armado_q;
  logic            aceptar;

  logic            modo_q;
  logic [31:0]     acc_q, acc_d, acc_base;
  logic [3:0]      ndig_q, ndig_d, ndig_base;
  logic            digito_stb_q, digito_stb_d;
  logic [3:0]      digito_q, digito_d;
  logic            monto_stb_q, monto_stb_d;
  logic [31:0]     monto_q, monto_d;

  // armado_q blocks a key still held across reset until it is released once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tecla_prev_q <= '0;
      armado_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tecla_prev_q <= tecla_prev_d;
      if (!bus.tecla_valida) armado_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.tarjeta_recibida) begin
      state_d = StSoltar;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.tecla_valida && armado_q) begin
            state_d = (DEBOUNCE_CYCLES <= 1) ? StAceptar : StFiltro;
          end
        end
        StFiltro: begin
          if (!bus.tecla_valida) begin
            state_d = StIdle;
          end else if (bus.tecla == tecla_prev_q && cnt_q == CntUltimo) begin
            state_d = StAceptar;
          end
        end
        StAceptar: state_d = StSoltar;
        StSoltar:  if (!bus.tecla_valida) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    tecla_prev_d = tecla_prev_q;
    aceptar      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.tarjeta_recibida && bus.tecla_valida && armado_q) begin
          tecla_prev_d = bus.tecla;
          cnt_d        = CntW'(1);
        end
      end
      StFiltro: begin
        if (bus.tarjeta_recibida && bus.tecla_valida) begin
          if (bus.tecla == tecla_prev_q) begin
            cnt_d = cnt_q + CntW'(1);
          end else begin
            tecla_prev_d = bus.tecla;
            cnt_d        = CntW'(1);
          end
        end
      end
      StAceptar: aceptar = bus.tarjeta_recibida;
      StSoltar:  cnt_d   = '0;
      default:   cnt_d   = '0;
    endcase
  end

  // A mode change or missing card wipes the accumulator before any key in the same cycle.
  always_comb begin
    if (!bus.tarjeta_recibida || (bus.modo_monto != modo_q)) begin
      acc_base  = '0;
      ndig_base = '0;
    end else begin
      acc_base  = acc_q;
      ndig_base = ndig_q;
    end

    acc_d        = acc_base;
    ndig_d       = ndig_base;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;

    if (aceptar) begin
      if (!bus.modo_monto) begin
        if (tecla_prev_q <= 4'd9) begin
          digito_d     = tecla_prev_q;
          digito_stb_d = 1'b1;
        end
      end else if (tecla_prev_q <= 4'd9) begin
        if (ndig_base < MaxDig) begin
          acc_d  = (acc_base << 3) + (acc_base << 1) + {28'd0, tecla_prev_q};
          ndig_d = ndig_base + 4'd1;
        end
      end else if (tecla_prev_q == TeclaEnter) begin
        if (ndig_base != 4'd0) begin
          monto_d     = acc_base;
          monto_stb_d = 1'b1;
          acc_d       = '0;
          ndig_d      = '0;
        end
      end else if (tecla_prev_q == TeclaClear) begin
        acc_d  = '0;
        ndig_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      modo_q       <= 1'b0;
      acc_q        <= '0;
      ndig_q       <= '0;
      digito_q     <= '0;
      digito_stb_q <= 1'b0;
      monto_q      <= '0;
      monto_stb_q  <= 1'b0;
    end else begin
      modo_q       <= bus.modo_monto;
      acc_q        <= acc_d;
      ndig_q       <= ndig_d;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
    end
  end

  assign bus.digito_stb  = digito_stb_q;
  assign bus.digito      = digito_q;
  assign bus.monto_stb   = monto_stb_q;
  assign bus.monto       = monto_q;
  assign bus.digitos_cnt = ndig_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: directed and random key presses checked against a
// press-level model of the PIN/amount rules.
module tb_teclado_cajero;

  localparam int unsigned Deb  = 4;
  localparam int unsigned MaxD = 9;

  logic clk = 1'b0;
  logic reset;

  teclado_cajero_if bus ();

  teclado_cajero #(
    .DEBOUNCE_CYCLES(Deb),
    .MAX_DIGITOS    (MaxD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit              m_mode;
  longint unsigned m_acc;
  int              m_n;
  int              m_digito;
  longint unsigned m_monto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_n   = 0;
  endtask

  task automatic set_mode(input bit m);
    @(negedge clk);
    bus.modo_monto = m;
    if (m != m_mode) model_clear();
    m_mode = m;
  endtask

  // One press: key held for 'hold' edges, then released for 'gap' edges.
  task automatic press(input logic [3:0] key, input int hold, input int gap);
    int          n_dig = 0, n_mon = 0, e_dig = 0, e_mon = 0, both = 0;
    int          v_dig = 0;
    logic [31:0] v_mon = 0;
    int          exp_dig = 0, exp_mon = 0;
    if (hold >= int'(Deb)) begin
      if (!m_mode) begin
        if (key <= 9) begin
          exp_dig  = 1;
          m_digito = int'(key);
        end
      end else if (key <= 9) begin
        if (m_n < int'(MaxD)) begin
          m_acc = m_acc * 10 + key;
          m_n++;
        end
      end else if (key == 4'hA) begin
        if (m_n > 0) begin
          exp_mon = 1;
          m_monto = m_acc;
          model_clear();
        end
      end else if (key == 4'hB) begin
        model_clear();
      end
    end
    for (int i = 0; i < hold + gap; i++) begin
      @(negedge clk);
      bus.tecla_valida = (i < hold);
      bus.tecla        = (i < hold) ? key : 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      if (bus.digito_stb) begin
        n_dig++;
        v_dig = int'(bus.digito);
        if (e_dig == 0) e_dig = i + 1;
      end
      if (bus.monto_stb) begin
        n_mon++;
        v_mon = bus.monto;
        if (e_mon == 0) e_mon = i + 1;
      end
      if (bus.digito_stb && bus.monto_stb) both++;
    end
    chk("digito_stb_count", n_dig, exp_dig);
    if (exp_dig != 0) begin
      chk("digito_stb_edge", e_dig, Deb + 1);
      chk("digito_at_stb", v_dig, m_digito);
    end
    chk("monto_stb_count", n_mon, exp_mon);
    if (exp_mon != 0) begin
      chk("monto_stb_edge", e_mon, Deb + 1);
      chk("monto_at_stb", v_mon, m_monto[31:0]);
    end
    chk("stb_overlap", both, 0);
    chk("digito_held", bus.digito, m_digito);
    chk("monto_held", bus.monto, m_monto[31:0]);
    chk("digitos_cnt", bus.digitos_cnt, m_n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digito"}, bus.digito, 0);
    chk({tag, "_digito_stb"}, bus.digito_stb, 0);
    chk({tag, "_monto"}, bus.monto, 0);
    chk({tag, "_monto_stb"}, bus.monto_stb, 0);
    chk({tag, "_digitos_cnt"}, bus.digitos_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n_held;
    reset                = 1'b1;
    bus.tarjeta_recibida = 1'b1;
    bus.modo_monto       = 1'b0;
    bus.tecla_valida     = 1'b0;
    bus.tecla            = 4'd0;
    m_mode = 0; m_digito = 0; m_monto = 0;
    model_clear();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // PIN digits
    press(4'd3, 6, 2);
    press(4'd7, 6, 2);
    press(4'd0, 6, 2);
    press(4'd9, 6, 2);
    press(4'hA, 6, 2);

    // Bounce 1,1,0,1,1,1,1 then release
    press(4'd5, 2, 1);
    press(4'd5, 4, 2);

    // Long hold never repeats
    press(4'd6, 50, 2);

    // Amount 1250
    set_mode(1'b1);
    press(4'd1, 5, 2);
    press(4'd2, 5, 2);
    press(4'd5, 5, 2);
    press(4'd0, 5, 2);
    press(4'hA, 5, 2);

    // 10 nines, 10th ignored
    for (int k = 0; k < 10; k++) press(4'd9, 4, 2);
    press(4'hA, 4, 2);

    // Clear then Enter gives nothing; then 8, Enter
    press(4'd4, 5, 2);
    press(4'hB, 5, 2);
    press(4'hA, 5, 2);
    press(4'd8, 5, 2);
    press(4'hA, 5, 2);

    // Leading zero and ignored codes
    press(4'd0, 5, 2);
    press(4'hD, 5, 2);
    press(4'd5, 5, 2);
    press(4'hA, 5, 2);

    // Card removed after three amount digits
    press(4'd1, 5, 2);
    press(4'd2, 5, 2);
    press(4'd3, 5, 2);
    @(negedge clk);
    bus.tarjeta_recibida = 1'b0;
    @(negedge clk);
    chk("card_low_digitos_cnt", bus.digitos_cnt, 0);
    chk("card_low_monto_held", bus.monto, m_monto[31:0]);
    @(negedge clk);
    bus.tarjeta_recibida = 1'b1;
    model_clear();
    press(4'hA, 5, 2);

    // Reset during FILTRO; key held across reset release is not accepted
    set_mode(1'b0);
    press(4'd2, 5, 2);
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    bus.tecla        = 4'd4;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("midpress_reset");
    m_mode = 0; m_digito = 0; m_monto = 0;
    model_clear();
    @(negedge clk);
    reset  = 1'b0;
    n_held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.digito_stb || bus.monto_stb) n_held++;
    end
    chk("held_after_reset_stb", n_held, 0);
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (2) @(negedge clk);
    press(4'd4, 5, 2);

    // Random presses, bounces and mode flips
    for (int k = 0; k < 60; k++) begin
      logic [3:0] key;
      if ($urandom_range(0, 7) == 0) set_mode(~m_mode);
      key = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      press(key, int'($urandom_range(1, Deb + 4)), int'($urandom_range(2, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
